spi_reg_bridge: RTL and testbench
=================================

Name: spi_reg_bridge

Overview:
- Byte-level command decoder downstream of the SPI slave shift stage.
- Consumes received bytes, turns them into register-bus writes/reads, and supplies the next transmit byte the slave loads on its tx request.
- Frame = one spi_ss low period: first byte is the command, following bytes are data, with the address auto-incrementing after each data byte.

Parameters:
- ADDR_W, 7, register address width; legal range 1..7 (taken from cmd[6:0]).
- STATUS_BYTE, 8'hA5, byte returned on MISO during the command byte.
- AUTO_INC, 1, 1 = address increments after each data byte; 0 = address held fixed.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-low reset (0 = reset asserted)
- ena  input  1  clock enable; when 0 all state holds and reg_wr/reg_rd are 0
- spi_ss  input  1  slave select from pin, active-low; high = frame idle/abort
- rx_valid  input  1  one-clk strobe: rx_data holds a complete received byte
- rx_data  input  8  received byte
- tx_req  input  1  one-clk strobe: slave is loading tx_data into its shifter now
- tx_data  output  8  byte offered to slave for next transmit
- reg_addr  output  ADDR_W  register bus address
- reg_wdata  output  8  register write data
- reg_wr  output  1  one-clk write strobe
- reg_rd  output  1  one-clk read strobe; reg_rdata is valid exactly 1 clk later
- reg_rdata  input  8  register read data
- busy  output  1  1 while state != IDLE
- frame_err  output  1  sticky: frame ended mid-command (no command byte received); cleared at the start of the next frame

Behaviour:
- Reset (rst=0, async): state=IDLE, tx_data=STATUS_BYTE, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, frame_err=0.
- States: IDLE, CMD, WR, RD_FETCH, RD.
- IDLE: on the spi_ss high->low edge (detected synchronously) -> CMD. Also clear frame_err and set tx_data=STATUS_BYTE.
- CMD: on rx_valid, latch reg_addr=rx_data[ADDR_W-1:0].
  - rx_data[7]=0 -> WR.
  - rx_data[7]=1 -> assert reg_rd for 1 clk in the same transition, then go to RD_FETCH.
- RD_FETCH: exactly 1 clk. Capture reg_rdata into tx_data, then -> RD.
- RD: on tx_req (the slave has now taken tx_data):
  - if AUTO_INC, reg_addr <= reg_addr+1, wrapping modulo 2^ADDR_W;
  - assert reg_rd at the new address the following clk;
  - go to RD_FETCH.
  - rx_valid bytes received in RD are ignored.
- WR: on rx_valid, pulse reg_wr for 1 clk with reg_wdata=rx_data at the current reg_addr.
  - Next clk, if AUTO_INC, reg_addr increments with wrap.
  - tx_data stays STATUS_BYTE in WR.
- spi_ss high in any state -> IDLE on the next clk. This overrides any simultaneous rx_valid/tx_req, and any in-flight reg_wr/reg_rd is suppressed in that clk.
  - If the state was CMD when spi_ss rose, set frame_err=1.
  - reg_addr holds its value.
- Simultaneous rx_valid and tx_req in CMD: the command is processed; tx_req is ignored because tx_data is already STATUS_BYTE.
- Timing requirement: a read prefetch completes within 3 clk of tx_req. This is guaranteed because one SPI bit takes at least 2 clk.
- reg_wr and reg_rd are never high in the same clk.
- ena=0 freezes the FSM. Strobes arriving while ena=0 are lost; the slave stage is gated by the same ena.

Test Plan:
- Reset: rst=0 mid-frame -> all outputs at reset values immediately (async); after release, state=IDLE and tx_data=8'hA5.
- Burst write: ss low, rx bytes 8'h05, 8'h11, 8'h22, ss high -> reg_wr pulses with (addr 5, data 8'h11) then (addr 6, data 8'h22); no reg_rd; frame_err=0.
- Burst read: ss low, rx 8'h83; registers 3=8'h3C, 4=8'h4D -> reg_rd at addr 3 the clk after rx_valid, tx_data=8'h3C next clk; after tx_req, reg_rd at addr 4, tx_data=8'h4D.
- Wrap: ADDR_W=7, write cmd 8'h7F with two data bytes -> writes at addr 127 then addr 0.
- Abort: ss low then high before any rx_valid -> frame_err=1, busy=0. Next ss low -> frame_err=0.
- Collision: spi_ss rises in the same clk as rx_valid in WR -> no reg_wr, state=IDLE; AUTO_INC=0 variant: two data bytes are both written to the same address.

Source files
------------

// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder behind an SPI slave shift stage.
// It turns received bytes into register-bus writes and reads, and supplies each byte to transmit.
module spi_reg_bridge #(
    parameter int         ADDR_W      = 7,
    parameter logic [7:0] STATUS_BYTE = 8'hA5,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              spi_ss,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    input  logic              tx_req,
    output logic [7:0]        tx_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [7:0]        reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [7:0]        reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD_FETCH, RD} state_t;

    state_t            state, state_next;
    logic              ss_q;
    logic              ss_fall;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [7:0]        wdata_q, wdata_next;
    logic [7:0]        tx_q, tx_next;
    logic              wr_q, wr_next;
    logic              rd_q, rd_next;
    logic              err_q, err_next;

    assign ss_fall = ss_q & ~spi_ss;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ss_q    <= 1'b1;
            addr_q  <= '0;
            wdata_q <= 8'h00;
            tx_q    <= STATUS_BYTE;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (ena) begin
            state   <= state_next;
            ss_q    <= spi_ss;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
            tx_q    <= tx_next;
            wr_q    <= wr_next;
            rd_q    <= rd_next;
            err_q   <= err_next;
        end
    end

    // A read strobe shares its clk with RD_FETCH, which captures the data at the end of that clk.
    always_comb begin
        state_next = state;
        addr_next  = addr_q;
        wdata_next = wdata_q;
        tx_next    = tx_q;
        wr_next    = 1'b0;
        rd_next    = 1'b0;
        err_next   = err_q;
        if (spi_ss) begin
            state_next = IDLE;
            if (state == CMD) begin
                err_next = 1'b1;
            end
        end else begin
            if (wr_q && AUTO_INC) begin
                addr_next = addr_q + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        state_next = CMD;
                        err_next   = 1'b0;
                        tx_next    = STATUS_BYTE;
                    end
                end
                CMD: begin
                    if (rx_valid) begin
                        addr_next = rx_data[ADDR_W-1:0];
                        if (rx_data[7]) begin
                            rd_next    = 1'b1;
                            state_next = RD_FETCH;
                        end else begin
                            state_next = WR;
                        end
                    end
                end
                WR: begin
                    if (rx_valid) begin
                        wr_next    = 1'b1;
                        wdata_next = rx_data;
                    end
                end
                RD_FETCH: begin
                    tx_next    = reg_rdata;
                    state_next = RD;
                end
                RD: begin
                    if (tx_req) begin
                        if (AUTO_INC) begin
                            addr_next = addr_q + 1'b1;
                        end
                        rd_next    = 1'b1;
                        state_next = RD_FETCH;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign tx_data   = tx_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q & ena;
    assign reg_rd    = rd_q & ena;
    assign busy      = (state != IDLE);
    assign frame_err = err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Bench for spi_reg_bridge: two instances (auto-increment on and off) share one stimulus stream,
// and the observed bus traffic is compared with addresses computed as (cmd address + byte index) mod 128.
module tb_spi_reg_bridge;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ena = 1'b1;
    logic       spi_ss = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_req = 1'b0;

    logic [7:0] tx_a, tx_b, wdata_a, wdata_b, rdata_a, rdata_b;
    logic [6:0] addr_a, addr_b;
    logic       wr_a, wr_b, rd_a, rd_b, busy_a, busy_b, err_a, err_b;

    logic [7:0]  mem [128];
    logic [7:0]  data_q [$];
    logic [14:0] wq_a [$], wq_b [$];
    logic [6:0]  rq_a [$], rq_b [$];
    int checks = 0;
    int failures = 0;
    int overlap = 0;

    always #5 clk = ~clk;

    // A register answers with its contents only while it is being read, so late captures pick up garbage.
    assign rdata_a = rd_a ? mem[addr_a] : ~mem[addr_a];
    assign rdata_b = rd_b ? mem[addr_b] : ~mem[addr_b];

    spi_reg_bridge #(.ADDR_W(7), .STATUS_BYTE(8'hA5), .AUTO_INC(1'b1)) dut_a (
        .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_data(tx_a), .reg_addr(addr_a), .reg_wdata(wdata_a), .reg_wr(wr_a),
        .reg_rd(rd_a), .reg_rdata(rdata_a), .busy(busy_a), .frame_err(err_a));

    spi_reg_bridge #(.ADDR_W(7), .STATUS_BYTE(8'hA5), .AUTO_INC(1'b0)) dut_b (
        .clk(clk), .rst(rst), .ena(ena), .spi_ss(spi_ss), .rx_valid(rx_valid), .rx_data(rx_data),
        .tx_req(tx_req), .tx_data(tx_b), .reg_addr(addr_b), .reg_wdata(wdata_b), .reg_wr(wr_b),
        .reg_rd(rd_b), .reg_rdata(rdata_b), .busy(busy_b), .frame_err(err_b));

    always @(negedge clk) begin
        if (rst) begin
            if (wr_a) wq_a.push_back({addr_a, wdata_a});
            if (wr_b) wq_b.push_back({addr_b, wdata_b});
            if (rd_a) rq_a.push_back(addr_a);
            if (rd_b) rq_b.push_back(addr_b);
            if ((wr_a && rd_a) || (wr_b && rd_b)) overlap++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation timed out");
    end

    function automatic logic [6:0] exp_addr(input logic [6:0] a0, input int k, input bit auto_inc);
        return auto_inc ? 7'((int'(a0) + k) % 128) : a0;
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_queues();
        wq_a.delete(); wq_b.delete(); rq_a.delete(); rq_b.delete();
    endtask

    task automatic frame_begin();
        clear_queues();
        spi_ss = 1'b0;
        step();
        check_output("busy_start", busy_a, 1'b1);
        check_output("tx_status_start", tx_a, 8'hA5);
        check_output("err_clear_start", err_a, 1'b0);
    endtask

    task automatic frame_end();
        spi_ss = 1'b1;
        step();
        check_output("busy_end_a", busy_a, 1'b0);
        check_output("busy_end_b", busy_b, 1'b0);
        check_output("err_end", err_a, 1'b0);
        step();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic apply_stimulus_write(input logic [6:0] a0);
        frame_begin();
        send_byte({1'b0, a0});
        step(2);
        foreach (data_q[i]) begin
            send_byte(data_q[i]);
            check_output("wr_strobe", wr_a, 1'b1);
            check_output("wr_addr_live", addr_a, exp_addr(a0, i, 1'b1));
            check_output("tx_in_wr", tx_a, 8'hA5);
            step(3);
        end
        frame_end();
        check_output("wr_count_a", wq_a.size(), data_q.size());
        check_output("wr_count_b", wq_b.size(), data_q.size());
        check_output("rd_none", rq_a.size() + rq_b.size(), 0);
        foreach (data_q[i]) begin
            if (i < wq_a.size()) check_output("wr_a", wq_a[i], {exp_addr(a0, i, 1'b1), data_q[i]});
            if (i < wq_b.size()) check_output("wr_b", wq_b[i], {exp_addr(a0, i, 1'b0), data_q[i]});
        end
    endtask

    task automatic apply_stimulus_read(input logic [6:0] a0, input int n);
        frame_begin();
        send_byte({1'b1, a0});
        check_output("rd_first_a", rd_a, 1'b1);
        check_output("rd_first_addr", addr_a, a0);
        check_output("rd_first_b", rd_b, 1'b1);
        step();
        check_output("rd_strobe_width", rd_a, 1'b0);
        check_output("tx_first_a", tx_a, mem[a0]);
        check_output("tx_first_b", tx_b, mem[a0]);
        for (int k = 1; k < n; k++) begin
            step(2);
            if (k == 1) begin
                send_byte(8'h5A);
                step();
            end
            tx_req = 1'b1;
            step();
            tx_req = 1'b0;
            check_output("rd_next_a", rd_a, 1'b1);
            check_output("rd_next_addr_a", addr_a, exp_addr(a0, k, 1'b1));
            check_output("rd_next_addr_b", addr_b, a0);
            step();
            check_output("tx_next_a", tx_a, mem[exp_addr(a0, k, 1'b1)]);
            check_output("tx_next_b", tx_b, mem[a0]);
        end
        step(2);
        frame_end();
        check_output("rd_count_a", rq_a.size(), n);
        check_output("rd_count_b", rq_b.size(), n);
        check_output("wr_none_in_read", wq_a.size() + wq_b.size(), 0);
        for (int k = 0; k < n; k++) begin
            if (k < rq_a.size()) check_output("rd_addr_a", rq_a[k], exp_addr(a0, k, 1'b1));
            if (k < rq_b.size()) check_output("rd_addr_b", rq_b[k], exp_addr(a0, k, 1'b0));
        end
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        mem[3] = 8'h3C;
        mem[4] = 8'h4D;

        step(2);
        check_output("reset_tx", tx_a, 8'hA5);
        check_output("reset_addr", addr_a, 7'd0);
        check_output("reset_wdata", wdata_a, 8'h00);
        check_output("reset_strobes", {wr_a, rd_a}, 2'b00);
        check_output("reset_busy_err", {busy_a, err_a}, 2'b00);
        rst = 1'b1;
        step(2);

        // Burst write, burst read, then an address wrap.
        data_q = '{8'h11, 8'h22};
        apply_stimulus_write(7'h05);
        apply_stimulus_read(7'h03, 2);
        data_q = '{8'($urandom), 8'($urandom)};
        apply_stimulus_write(7'h7F);

        // Frame dropped before any command byte.
        clear_queues();
        spi_ss = 1'b0;
        step();
        check_output("abort_busy_on", busy_a, 1'b1);
        step(3);
        spi_ss = 1'b1;
        step();
        check_output("abort_err_a", err_a, 1'b1);
        check_output("abort_err_b", err_b, 1'b1);
        check_output("abort_busy_off", busy_a, 1'b0);
        step(3);
        check_output("abort_err_sticky", err_a, 1'b1);
        spi_ss = 1'b0;
        step();
        check_output("abort_err_cleared", err_a, 1'b0);
        send_byte(8'h12);
        step(2);
        frame_end();
        check_output("abort_no_traffic", wq_a.size() + rq_a.size(), 0);

        // Select rises together with a data byte: that byte is never written.
        frame_begin();
        send_byte(8'h10);
        step(2);
        send_byte(8'h55);
        step(3);
        spi_ss   = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h66;
        step();
        rx_valid = 1'b0;
        check_output("collide_busy", busy_a, 1'b0);
        check_output("collide_no_wr", wr_a, 1'b0);
        check_output("collide_err", err_a, 1'b0);
        step(2);
        check_output("collide_count", wq_a.size(), 1);
        if (wq_a.size() > 0) check_output("collide_entry", wq_a[0], {7'h10, 8'h55});

        // A byte arriving while ena is low is lost and does not advance the address.
        frame_begin();
        send_byte(8'h20);
        step(2);
        ena = 1'b0;
        send_byte(8'h77);
        check_output("ena_low_no_wr", wr_a, 1'b0);
        check_output("ena_low_busy", busy_a, 1'b1);
        ena = 1'b1;
        step(2);
        send_byte(8'h88);
        check_output("ena_resume_wr", wr_a, 1'b1);
        step(3);
        frame_end();
        check_output("ena_count", wq_a.size(), 1);
        if (wq_a.size() > 0) check_output("ena_entry", wq_a[0], {7'h20, 8'h88});

        // Randomized frames.
        repeat (6) begin
            data_q.delete();
            repeat ($urandom_range(1, 4)) data_q.push_back(8'($urandom));
            apply_stimulus_write(7'($urandom));
        end
        repeat (6) apply_stimulus_read(7'($urandom), int'($urandom_range(1, 4)));

        // Asynchronous reset in the middle of a write strobe.
        frame_begin();
        send_byte(8'h40);
        step(2);
        send_byte(8'h9C);
        check_output("pre_reset_wr", wr_a, 1'b1);
        #2 rst = 1'b0;
        #1;
        check_output("async_tx", tx_a, 8'hA5);
        check_output("async_addr", addr_a, 7'd0);
        check_output("async_wdata", wdata_a, 8'h00);
        check_output("async_strobes", {wr_a, rd_a}, 2'b00);
        check_output("async_busy_err", {busy_a, err_a}, 2'b00);
        spi_ss = 1'b1;
        step(2);
        rst = 1'b1;
        step(2);
        check_output("post_reset_busy", busy_a, 1'b0);
        check_output("post_reset_tx", tx_a, 8'hA5);
        data_q = '{8'hC3};
        apply_stimulus_write(7'h2A);

        check_output("wr_rd_exclusive", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
